switch_debouncer: RTL and testbench



---
 rtl/switch_debouncer_pkg.sv | 15 +
 rtl/debounce_bit.sv | 52 +++++
 rtl/switch_debouncer.sv | 36 +++
 tb/tb_switch_debouncer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/switch_debouncer_pkg.sv
// Shared timing constants for the switch conditioning path, plus a helper that
// checks whether a stability counter is wide enough.
package switch_debouncer_pkg;

    localparam int unsigned CLK_HZ          = 50_000_000;
    localparam int unsigned DEBOUNCE_MS     = 20;
    localparam int unsigned DEBOUNCE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

    // True when a cnt_w-bit counter can hold stable_cycles-1.
    function automatic bit cnt_w_ok(input int unsigned stable_cycles, input int unsigned cnt_w);
        if (cnt_w >= 32'd32) return 1'b1;
        return (64'd1 << cnt_w) > 64'(stable_cycles - 32'd1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch: two-flop synchroniser, stability counter, debounced level and
// registered rise/fall pulses.
module debounce_bit #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sw_i,
    output logic state_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic [CNT_W-1:0] cnt_q;
    logic             state_q, rise_q, fall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            state_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q   <= sw_i;
            s2_q   <= s1_q;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            // Any cycle where s2 agrees with the accepted level discards the count.
            if (s2_q == state_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                state_q <= s2_q;
                cnt_q   <= '0;
                rise_q  <= s2_q;
                fall_q  <= ~s2_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign state_o = state_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH slide switches; STATE feeds the display logic, RISE/FALL feed
// event logic such as counters.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned WIDTH         = 6,
    parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W         = 20
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [WIDTH-1:0] SW,
    output logic [WIDTH-1:0] STATE,
    output logic [WIDTH-1:0] RISE,
    output logic [WIDTH-1:0] FALL
);

    if (STABLE_CYCLES < 2 || !cnt_w_ok(STABLE_CYCLES, CNT_W)) begin : g_bad_params
        $error("switch_debouncer: STABLE_CYCLES must be >= 2 and STABLE_CYCLES-1 must fit in CNT_W");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_bit (
            .clk_i  (CLOCK_50),
            .rst_i  (RESET),
            .sw_i   (SW[i]),
            .state_o(STATE[i]),
            .rise_o (RISE[i]),
            .fall_o (FALL[i])
        );
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed and randomised bench for switch_debouncer; a sliding-window model of
// the accept rule predicts every output cycle by cycle.
module tb_switch_debouncer;

    localparam int unsigned WIDTH  = 6;
    localparam int unsigned STABLE = 4;
    localparam int unsigned CNT_W  = 3;

    logic             CLOCK_50 = 1'b0;
    logic             RESET;
    logic [WIDTH-1:0] SW;
    logic [WIDTH-1:0] STATE, RISE, FALL;

    int checks = 0;
    int errors = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    switch_debouncer #(
        .WIDTH        (WIDTH),
        .STABLE_CYCLES(STABLE),
        .CNT_W        (CNT_W)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET   (RESET),
        .SW      (SW),
        .STATE   (STATE),
        .RISE    (RISE),
        .FALL    (FALL)
    );

    // Reference: a level is accepted at edge n when the SW samples taken at
    // edges n-2 .. n-1-STABLE all differ from the accepted level.
    // hist[0] is the sample from the previous edge.
    logic [WIDTH-1:0] hist[$];
    logic [WIDTH-1:0] m_state, m_rise, m_fall;

    always @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            hist.delete();
            for (int j = 0; j <= STABLE; j++) hist.push_back('0);
            m_state = '0;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < WIDTH; b++) begin
                bit held;
                held = 1'b1;
                for (int j = 1; j <= STABLE; j++) if (hist[j][b] == m_state[b]) held = 1'b0;
                if (held) begin
                    m_state[b] = hist[1][b];
                    if (hist[1][b]) m_rise[b] = 1'b1;
                    else            m_fall[b] = 1'b1;
                end
            end
            hist.push_front(SW);
            void'(hist.pop_back());
        end
    end

    task automatic expect_vec(input string tag, input logic [WIDTH-1:0] got,
                              input logic [WIDTH-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %b, expected %b", tag, got, exp);
        end
    endtask

    // Advance one clock, then compare all outputs with the model.
    task automatic step();
        @(posedge CLOCK_50);
        #1;
        expect_vec("model_state", STATE, m_state);
        expect_vec("model_rise", RISE, m_rise);
        expect_vec("model_fall", FALL, m_fall);
        expect_vec("rise_fall_excl", RISE & FALL, '0);
    endtask

    initial begin
        int rc, fc, re;
        logic [WIDTH-1:0] es, er, ef;

        // 1. Reset with all switches high, then release.
        RESET = 1'b1;
        SW    = 6'b111111;
        repeat (3) begin
            step();
            expect_vec("reset_state", STATE, '0);
            expect_vec("reset_rise", RISE, '0);
            expect_vec("reset_fall", FALL, '0);
        end
        RESET = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            expect_vec("rel_state", STATE, (e >= 6) ? 6'b111111 : 6'b000000);
            expect_vec("rel_rise", RISE, (e == 6) ? 6'b111111 : 6'b000000);
            expect_vec("rel_fall", FALL, '0);
        end

        // 2. Clean edge on SW[2] after settling all low.
        SW = '0;
        repeat (10) step();
        expect_vec("settle_low", STATE, '0);
        SW[2] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            expect_vec("clean_state", STATE, (e >= 6) ? 6'b000100 : 6'b000000);
            expect_vec("clean_rise", RISE, (e == 6) ? 6'b000100 : 6'b000000);
        end

        // 3. A 3-cycle glitch is rejected; a 4-cycle pulse is accepted.
        SW[0] = 1'b1;
        for (int e = 1; e <= 11; e++) begin
            if (e == 4) SW[0] = 1'b0;
            step();
            expect_vec("glitch_state", STATE, 6'b000100);
            expect_vec("glitch_evt", RISE | FALL, '0);
        end
        SW[0] = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 5) SW[0] = 1'b0;
            step();
            expect_vec("pulse_state", STATE, (e >= 6 && e < 10) ? 6'b000101 : 6'b000100);
            expect_vec("pulse_rise", RISE, (e == 6) ? 6'b000001 : 6'b000000);
            expect_vec("pulse_fall", FALL, (e == 10) ? 6'b000001 : 6'b000000);
        end

        // 4. Bounce on SW[1]: 1,0,1,0,1 then hold.
        rc = 0; fc = 0; re = 0;
        for (int k = 0; k < 5; k++) begin
            SW[1] = (k % 2 == 0);
            step();
            if (RISE[1]) rc++;
            if (FALL[1]) fc++;
        end
        for (int e = 2; e <= 12; e++) begin
            step();
            if (RISE[1]) begin rc++; re = e; end
            if (FALL[1]) fc++;
        end
        checks++;
        assert (rc == 1 && re == 6 && fc == 0) else begin
            errors++;
            $error("FAIL bounce: rises %0d at edge %0d falls %0d, expected 1 at edge 6 and 0",
                   rc, re, fc);
        end
        expect_vec("bounce_state", STATE, 6'b000110);

        // 5. Simultaneous rise on SW[3] and fall on SW[4].
        SW[4] = 1'b1;
        repeat (10) step();
        expect_vec("sim_pre", STATE, 6'b010110);
        SW[3] = 1'b1;
        SW[4] = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            expect_vec("sim_rise", RISE, (e == 6) ? 6'b001000 : 6'b000000);
            expect_vec("sim_fall", FALL, (e == 6) ? 6'b010000 : 6'b000000);
            expect_vec("sim_state", STATE, (e >= 6) ? 6'b001110 : 6'b010110);
        end

        // 6. Reset in the middle of SW[5]'s count.
        rc = 0;
        SW[5] = 1'b1;
        repeat (3) begin
            step();
            if (RISE[5]) rc++;
        end
        RESET = 1'b1;
        step();
        expect_vec("mid_reset", STATE | RISE | FALL, '0);
        RESET = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (RISE[5]) rc++;
            expect_vec("mid_state", STATE, (e >= 6) ? 6'b101110 : 6'b000000);
            expect_vec("mid_rise", RISE, (e == 6) ? 6'b101110 : 6'b000000);
        end
        checks++;
        assert (rc == 1) else begin
            errors++;
            $error("FAIL mid_rise_count: got %0d, expected 1", rc);
        end

        // 7. Random levels with random hold lengths, checked against the model.
        for (int k = 0; k < 120; k++) begin
            SW = WIDTH'($urandom);
            repeat ($urandom_range(1, 7)) step();
            if (k == 60) begin
                RESET = 1'b1;
                step();
                RESET = 1'b0;
            end
        end
        repeat (10) step();

        es = m_state; er = m_rise; ef = m_fall;
        expect_vec("final_state", STATE, es);
        expect_vec("final_evt", RISE | FALL, er | ef);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
